pl_muldiv_ctrl: RTL
===================

Name: pl_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the RV32M extension. It sits in the execute stage beside the single-cycle ALU. It takes operands and a 3-bit M-op when the EX stage dispatches one, runs a W-step shift-add or restoring-divide loop, and returns a single registered result with a one-cycle done pulse. The hazard unit holds the pipeline while busy=1.

Parameters:
W, 32, operand/result width; must be ≥2; step counter is $clog2(W)+1 bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
flush  input  1  abort any operation in progress (branch mispredict/trap)
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src_a  input  W  rs1 operand (multiplicand/dividend)
src_b  input  W  rs2 operand (multiplier/divisor)
busy  output  1  high from the cycle after start is accepted until the done cycle inclusive
done  output  1  one-cycle pulse; result valid
result  output  W  registered result; held until the next accepted start

Behaviour:
- Reset (rst=1 at clock edge, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared. Reset mid-operation discards the operation and produces no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → latch op.
  - Latch |src_a| and |src_b| as magnitudes. src_a is signed for MULH, MULHSU, DIV, REM. src_b is signed for MULH, DIV, REM. Otherwise operands are taken as unsigned.
  - Latch result-sign flags.
  - Divide special cases go straight to DONE:
    - divisor=0: DIV/DIVU → all ones; REM/REMU → src_a.
    - DIV/REM with src_a=most-negative and src_b=−1: DIV → src_a; REM → 0.
  - All other ops → RUN, counter=0.
- RUN: one step per cycle, exactly W cycles (counter 0..W−1), then → FIX.
  - Multiply: 2W-bit product, shift-add on the multiplier LSB.
  - Divide: restoring. Shift {rem,quot} left; subtract the divisor if non-negative; set the quotient bit.
- FIX: one cycle, then → DONE.
  - Apply two's-complement negation to the product or quotient when the sign flags differ.
  - The remainder takes the dividend's sign.
  - Select the output: MUL = low W bits; MULH/MULHSU/MULHU = high W bits.
  - Load result.
- DONE: done=1 for exactly this cycle, then → IDLE.
- busy is 1 in RUN, FIX, DONE; 0 in IDLE.
- Latency (start edge = cycle 0):
  - normal ops: done in cycle W+2 (34 for W=32).
  - special-case divides: done in cycle 1.
- start while busy is ignored; no queueing.
- flush=1 in RUN/FIX/DONE → IDLE next edge, done not asserted, result unchanged.
- flush and start both high in IDLE → flush wins, start is not accepted.
- Operand inputs may change after acceptance; only the latched copies are used.
- All arithmetic is modulo 2^W (2^2W for the product). No exceptions or flags are raised.

Decomposition:
- Package pl_muldiv_pkg:
  - muldiv_op_e enum (8 op codes above).
  - muldiv_state_e enum (IDLE/RUN/FIX/DONE).
  - Helper functions is_div(op), a_signed(op), b_signed(op).
  - Constant MULDIV_OPW=3.
- One sub-module, pl_muldiv_step: combinational single-iteration step. Given op class, accumulator, multiplier/quotient and divisor, it returns the next accumulator and quotient. The controller holds the FSM, counter, sign fix and output registers.

Test Plan:
- MUL src_a=7, src_b=6 → done pulse in cycle 34, result=42, busy high cycles 1–34.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with done in cycle 1. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, done in cycle 1. REM same operands → 0.
- Start DIV 100/7, assert flush at cycle 10 → busy=0 in cycle 11, no done, result keeps the prior value. Immediately start MUL 3×4 → 12 in cycle 34.
- Start MUL, assert rst at cycle 15 → busy=0, done=0, result=0 next cycle. A start pulse during busy (cycle 5) is ignored and does not change the result or latency.

Source files
------------

// File: rtl/pl_muldiv_pkg.sv
// Shared types and op-class helpers for the RV32M multiply/divide sequencer.
package pl_muldiv_pkg;

  localparam int MULDIV_OPW = 3;

  typedef enum logic [MULDIV_OPW-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic a_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/pl_muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide loop on unsigned magnitudes.
module pl_muldiv_step
  import pl_muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         div_mode,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] add_sum;
  logic [W:0] mul_sel;
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       fits;

  always_comb begin
    add_sum  = {1'b0, acc} + {1'b0, opnd};
    shifted  = {acc, quo[W-1]};
    diff     = shifted - {1'b0, opnd};
    fits     = (shifted >= {1'b0, opnd});
    mul_sel  = quo[0] ? add_sum : {1'b0, acc};
    acc_next = acc;
    quo_next = quo;
    if (div_mode) begin
      // the partial remainder always stays below the divisor, so W bits suffice after the step
      acc_next = fits ? diff[W-1:0] : shifted[W-1:0];
      quo_next = {quo[W-2:0], fits};
    end else begin
      // {acc,quo} is the 2W-bit product register; the multiplier drains out of quo's LSB
      acc_next = mul_sel[W:1];
      quo_next = {mul_sel[0], quo[W-1:1]};
    end
  end

endmodule

// File: rtl/pl_muldiv_ctrl.sv
// RV32M iterative multiply/divide sequencer: FSM, step counter, sign fix-up and result register.
module pl_muldiv_ctrl
  import pl_muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [MULDIV_OPW-1:0] op,
  input  logic [W-1:0]          src_a,
  input  logic [W-1:0]          src_b,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          result
);

  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST     = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e state, state_d;
  muldiv_op_e    op_in, op_q;

  logic [W-1:0]   acc, quo, opnd;
  logic [W-1:0]   acc_step, quo_step;
  logic [CW-1:0]  cnt;
  logic           neg_res, neg_rem;

  logic           accept, a_neg, b_neg, div_zero, div_ovf, special;
  logic [W-1:0]   a_mag, b_mag, special_res;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    op_in    = muldiv_op_e'(op);
    accept   = (state == ST_IDLE) && start && !flush;
    a_neg    = a_signed(op_in) && src_a[W-1];
    b_neg    = b_signed(op_in) && src_b[W-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = is_div(op_in) && (src_b == '0);
    div_ovf  = is_div(op_in) && a_signed(op_in) && (src_a == MOST_NEG) && (src_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = is_rem(op_in) ? src_a : '1;
    else          special_res = is_rem(op_in) ? '0 : src_a;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt == LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush && (state != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    prod     = {acc, quo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = neg_rem ? -acc : acc;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  pl_muldiv_step #(.W(W)) u_step (
    .div_mode (is_div(op_q)),
    .acc      (acc),
    .quo      (quo),
    .opnd     (opnd),
    .acc_next (acc_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_MUL;
      acc     <= '0;
      quo     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= '0;
            acc     <= '0;
            // divide iterates over the dividend; multiply iterates over the multiplier
            quo     <= is_div(op_in) ? a_mag : b_mag;
            opnd    <= is_div(op_in) ? b_mag : a_mag;
            if (special) result <= special_res;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc <= acc_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
          end
        end
        ST_FIX: begin
          if (!flush) result <= fix_res;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

endmodule
